// File: rtl/mont_mult.sv
// rtl/mont_mult.sv - radix-2 Montgomery multiplier, P = a*b*2^-k mod n
//
// Purpose:
//   Bit-serial Montgomery product with a run-time iteration count k = op_len.
//   Each CALC cycle consumes one bit of a (LSB first). The accumulator adds b
//   when that bit is set, and adds n when the sum is odd. It then halves, so
//   acc stays below 2n and fits in WIDTH+2 bits.
//
// Configuration macro:
//   MONT_FINAL_SUB_EN - when defined, FINAL applies one conditional
//                       subtraction of n, so p < n. When undefined, p is the
//                       unreduced accumulator (p < 2n) and no subtractor is
//                       built.
//
// Ports:
//   clk     in   1            rising-edge clock
//   rst_n   in   1            asynchronous active-low reset
//   start   in   1            request, sampled only in IDLE
//   op_len  in   LOG_WIDTH+1  iteration count k, legal 1..WIDTH
//   a       in   WIDTH        multiplier, bit i used on iteration i
//   b       in   WIDTH        multiplicand, b < n
//   n       in   WIDTH        modulus, must be odd
//   busy    out  1            operation in progress
//   done    out  1            one-cycle pulse, result or error valid
//   err     out  1            with done: request was rejected
//   p       out  WIDTH+1      result, held until the next done

module mont_mult #(
  parameter int WIDTH     = 256,
  parameter int LOG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LOG_WIDTH:0]   op_len,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     n,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH:0]       p
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [LOG_WIDTH:0] MAX_LEN = (LOG_WIDTH+1)'(WIDTH);

  state_t                 state, state_nx;
  logic [WIDTH-1:0]       a_r, a_nx;
  logic [WIDTH-1:0]       b_r, b_nx;
  logic [WIDTH-1:0]       n_r, n_nx;
  logic [WIDTH+1:0]       acc, acc_nx;
  logic [LOG_WIDTH-1:0]   idx, idx_nx;
  logic [LOG_WIDTH:0]     cnt, cnt_nx;
  logic                   rej_pend, rej_pend_nx;
  logic                   busy_nx, done_nx, err_nx;
  logic [WIDTH:0]         p_nx;

  logic                   legal;
  logic [WIDTH+1:0]       t_add;
  logic [WIDTH+1:0]       t_odd;
  logic [WIDTH:0]         p_final;

  assign legal = (op_len != '0) && (op_len <= MAX_LEN) && n[0];

  // One Montgomery step: acc < 2n and b < n keep the sum below 4n, so the
  // WIDTH+2 bit datapath never overflows.
  assign t_add = acc + (a_r[idx] ? {2'b00, b_r} : '0);
  assign t_odd = t_add[0] ? (t_add + {2'b00, n_r}) : t_add;

`ifdef MONT_FINAL_SUB_EN
  logic           borrow;
  logic [WIDTH:0] diff;

  // acc < 2n < 2^(WIDTH+1), so acc[WIDTH+1] is always zero here.
  // The borrow out tells whether acc - n is negative.
  assign {borrow, diff} = {1'b0, acc[WIDTH:0]} - {2'b00, n_r};
  assign p_final = borrow ? acc[WIDTH:0] : diff;
`else
  assign p_final = acc[WIDTH:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      n_r      <= '0;
      acc      <= '0;
      idx      <= '0;
      cnt      <= '0;
      rej_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      p        <= '0;
    end else begin
      state    <= state_nx;
      a_r      <= a_nx;
      b_r      <= b_nx;
      n_r      <= n_nx;
      acc      <= acc_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      rej_pend <= rej_pend_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      err      <= err_nx;
      p        <= p_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    a_nx        = a_r;
    b_nx        = b_r;
    n_nx        = n_r;
    acc_nx      = acc;
    idx_nx      = idx;
    cnt_nx      = cnt;
    rej_pend_nx = 1'b0;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    p_nx        = p;

    case (state)
      IDLE: begin
        if (rej_pend) begin
          // The rejection reported one cycle after the request. Any start in
          // this cycle is not looked at.
          done_nx = 1'b1;
          err_nx  = 1'b1;
        end else if (start) begin
          if (legal) begin
            a_nx     = a;
            b_nx     = b;
            n_nx     = n;
            acc_nx   = '0;
            idx_nx   = '0;
            cnt_nx   = op_len;
            state_nx = CALC;
          end else begin
            rej_pend_nx = 1'b1;
          end
        end
      end
      CALC: begin
        acc_nx = t_odd >> 1;
        idx_nx = idx + LOG_WIDTH'(1);
        cnt_nx = cnt - (LOG_WIDTH+1)'(1);
        if (cnt == (LOG_WIDTH+1)'(1)) begin
          state_nx = FINAL;
        end
      end
      FINAL: begin
        p_nx     = p_final;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_mont_mult.sv
// tb/tb_mont_mult.sv - self-checking bench for mont_mult (8-bit and 256-bit instances)

module tb_mont_mult;

  logic clk = 1'b0;
  logic rst_n;

  logic         s8;
  logic [3:0]   len8;
  logic [7:0]   a8, b8, n8;
  logic         busy8, done8, err8;
  logic [8:0]   p8;

  logic         s2;
  logic [8:0]   len2;
  logic [255:0] a2, b2, n2;
  logic         busy2, done2, err2;
  logic [256:0] p2;

  int tests = 0;
  int fails = 0;

`ifdef MONT_FINAL_SUB_EN
  localparam logic [8:0] EXP_SUB = 9'd8;
`else
  localparam logic [8:0] EXP_SUB = 9'd21;
`endif

  always #5 clk = ~clk;

  mont_mult #(.WIDTH(8), .LOG_WIDTH(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .op_len(len8),
    .a(a8), .b(b8), .n(n8),
    .busy(busy8), .done(done8), .err(err8), .p(p8)
  );

  mont_mult #(.WIDTH(256), .LOG_WIDTH(8)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(s2), .op_len(len2),
    .a(a2), .b(b2), .n(n2),
    .busy(busy2), .done(done2), .err(err2), .p(p2)
  );

  typedef struct {
    string      name;
    logic [7:0] a, b, n;
    int         len;
    logic [8:0] p;
    logic       e;
    int         lat;
    int         bc;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // a*b*2^-k mod n from plain modular arithmetic. Only the low k bits of a
  // take part. Division by 2 mod odd n is done as (x or x+n)/2.
  function automatic logic [511:0] mont_ref(input logic [255:0] av, input logic [255:0] bv,
                                            input logic [255:0] nv, input int k);
    logic [511:0] am, x, nn;
    am = {256'b0, av};
    if (k < 256) am = am & ((512'd1 << k) - 512'd1);
    nn = {256'b0, nv};
    x  = (am * {256'b0, bv}) % nn;
    for (int i = 0; i < k; i++) x = x[0] ? ((x + nn) >> 1) : (x >> 1);
    return x;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issue one request and wait for done. lat counts edges after the
  // accepting edge up to the one that raised done. bc counts post-edge
  // samples with busy high.
  task automatic run(input bit big, input logic [255:0] av, input logic [255:0] bv,
                     input logic [255:0] nv, input int len,
                     output logic [256:0] pv, output logic ev, output int lat, output int bc);
    logic d, bz;
    @(negedge clk);
    if (big) begin a2 = av; b2 = bv; n2 = nv; len2 = len[8:0]; s2 = 1'b1; end
    else     begin a8 = av[7:0]; b8 = bv[7:0]; n8 = nv[7:0]; len8 = len[3:0]; s8 = 1'b1; end
    @(posedge clk); #1;
    s8 = 1'b0; s2 = 1'b0;
    bc  = big ? int'(busy2) : int'(busy8);
    lat = 0;
    d   = 1'b0;
    while (lat < 600 && !d) begin
      @(posedge clk); #1;
      lat++;
      d  = big ? done2 : done8;
      bz = big ? busy2 : busy8;
      if (!d && bz) bc++;
    end
    if (!d) begin
      fails++; tests++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
    end
    pv = big ? p2 : {248'b0, p8};
    ev = big ? err2 : err8;
    if (!big) check("busy_in_done_cycle", busy8, 0);
    @(posedge clk); #1;
    check("done_one_cycle", big ? done2 : done8, 0);
  endtask

  initial begin
    logic [256:0] pv;
    logic         ev;
    int           lat, bc, cnt;
    logic [255:0] ra, rb, rn;
    logic [511:0] ex;
    int           rl;

    vt[0] = '{"basic",     8'd5,  8'd7,  8'd13,  4, 9'd3,    1'b0, 5, 5};
    vt[1] = '{"final_sub", 8'd15, 8'd12, 8'd13,  4, EXP_SUB, 1'b0, 5, 5};
    vt[2] = '{"full_w",    8'd1,  8'd1,  8'd251, 8, 9'd201,  1'b0, 9, 9};
    vt[3] = '{"rej_even",  8'd5,  8'd7,  8'd12,  4, 9'd201,  1'b1, 1, 0};
    vt[4] = '{"rej_len0",  8'd5,  8'd7,  8'd13,  0, 9'd201,  1'b1, 1, 0};
    vt[5] = '{"rej_len9",  8'd5,  8'd7,  8'd13,  9, 9'd201,  1'b1, 1, 0};

    s8 = 0; len8 = 0; a8 = 0; b8 = 0; n8 = 0;
    s2 = 0; len2 = 0; a2 = 0; b2 = 0; n2 = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_err",  err8,  0);
    check("rst_p",    p8,    0);
    check("rst_p256", p2,    0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run(1'b0, {248'b0, vt[i].a}, {248'b0, vt[i].b}, {248'b0, vt[i].n}, vt[i].len, pv, ev, lat, bc);
      check({vt[i].name, "_p"},    pv,  vt[i].p);
      check({vt[i].name, "_err"},  ev,  vt[i].e);
      check({vt[i].name, "_lat"},  lat, vt[i].lat);
      check({vt[i].name, "_busy"}, bc,  vt[i].bc);
    end

    // Start while busy: a second request with new operands is dropped, and
    // port changes after acceptance do not disturb the running operation.
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd7; n8 = 8'd13; len8 = 4'd4; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    @(negedge clk);
    a8 = 8'd15; b8 = 8'd12; n8 = 8'd13; len8 = 4'd2; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    cnt = 0;
    while (cnt < 20 && !done8) begin @(negedge clk); cnt++; end
    check("busy_start_done_seen", done8, 1);
    check("busy_start_p",   p8,   3);
    check("busy_start_err", err8, 0);
    cnt = 0;
    repeat (8) begin @(negedge clk); if (done8 || busy8) cnt++; end
    check("busy_start_not_queued", cnt, 0);
    run(1'b0, 256'd15, 256'd12, 256'd13, 4, pv, ev, lat, bc);
    check("after_busy_p",   pv,  EXP_SUB);
    check("after_busy_lat", lat, 5);

    // Reset in the middle of CALC.
    run(1'b0, 256'd5, 256'd7, 256'd13, 4, pv, ev, lat, bc);
    @(negedge clk);
    a8 = 8'd15; b8 = 8'd12; n8 = 8'd13; len8 = 4'd4; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_err",  err8,  0);
    check("midrst_p",    p8,    0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin @(negedge clk); if (done8 || busy8) cnt++; end
    check("midrst_no_done", cnt, 0);
    run(1'b0, 256'd5, 256'd7, 256'd13, 4, pv, ev, lat, bc);
    check("midrst_after_p",   pv,  3);
    check("midrst_after_lat", lat, 5);

    // Random 8-bit operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      rn = {248'b0, 8'($urandom | 1)};
      rb = {248'b0, 8'($urandom)} % rn;
      ra = {248'b0, 8'($urandom)};
      rl = $urandom_range(1, 8);
      run(1'b0, ra, rb, rn, rl, pv, ev, lat, bc);
      ex = mont_ref(ra, rb, rn, rl);
`ifdef MONT_FINAL_SUB_EN
      check("rnd8_p", {255'b0, pv}, ex);
`else
      check("rnd8_p_mod", {255'b0, pv} % {256'b0, rn}, ex);
      check("rnd8_p_lt2n", ({255'b0, pv} < ({256'b0, rn} << 1)), 1);
`endif
      check("rnd8_err", ev,  0);
      check("rnd8_lat", lat, rl + 1);
    end

    // Random 256-bit operations. The first one uses the full length.
    for (int i = 0; i < 10; i++) begin
      rn = rand256() | 256'd1;
      rb = rand256() % rn;
      ra = rand256();
      rl = (i == 0) ? 256 : int'($urandom_range(1, 256));
      run(1'b1, ra, rb, rn, rl, pv, ev, lat, bc);
      ex = mont_ref(ra, rb, rn, rl);
`ifdef MONT_FINAL_SUB_EN
      check("rnd256_p", {255'b0, pv}, ex);
`else
      check("rnd256_p_mod", {255'b0, pv} % {256'b0, rn}, ex);
      check("rnd256_p_lt2n", ({255'b0, pv} < ({256'b0, rn} << 1)), 1);
`endif
      check("rnd256_err",  ev,  0);
      check("rnd256_lat",  lat, rl + 1);
      check("rnd256_busy", bc,  rl + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
